// File: rtl/ballot_unit.sv
// ballot_unit: polling-booth voter front end. Arms one ballot per officer
// unlock, synchronises and debounces the candidate buttons, and emits one
// single-cycle one-hot vote pulse toward the per-candidate counters.
//
// Ports:
//   clk         system clock, rising edge
//   clear       asynchronous active-high reset
//   i_unlock    officer unlock, single-cycle pulse (honoured only when locked)
//   i_buttons   raw asynchronous candidate buttons, active-high
//   o_vote      one-hot, one-cycle vote pulse, bit k -> counter k
//   o_enable_n  active-low counter enable (1 only while clear is asserted)
//   o_ready     ballot armed, waiting for a choice
//   o_reject    one-cycle pulse on a multi-button press while armed
//   o_timeout   one-cycle pulse when an armed ballot expires
//
// Optional feature: define BALLOT_TIMEOUT_EN to add the armed-ballot
// expiry timer (TIMEOUT_CYCLES). Without it o_timeout is always 0 and an
// armed ballot waits indefinitely.

module ballot_unit #(
    parameter int N_CAND          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              i_unlock,
    input  logic [N_CAND-1:0] i_buttons,
    output logic [N_CAND-1:0] o_vote,
    output logic              o_enable_n,
    output logic              o_ready,
    output logic              o_reject,
    output logic              o_timeout
);

    if (N_CAND < 2 || N_CAND > 16 ||
        DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ballot_unit: parameter out of range");
    end

    typedef enum logic [2:0] {
        LOCKED,
        ARMED,
        DEBOUNCE,
        CAST,
        RELEASE,
        RELEASE_WAIT_ARMED
    } state_t;

    localparam logic [15:0] DBC_LIM = 16'(DEBOUNCE_CYCLES);

    state_t            state;
    state_t            state_nx;
    logic [N_CAND-1:0] sync1;
    logic [N_CAND-1:0] sync_s;
    logic [N_CAND-1:0] sel;
    logic [N_CAND-1:0] sel_nx;
    logic [15:0]       cnt;
    logic [15:0]       cnt_nx;
    logic [15:0]       cnt_inc;
    logic [N_CAND-1:0] vote_nx;
    logic              reject_nx;
    logic              tmo_nx;
    logic              tmo_q;
    logic              s_any;
    logic              s_multi;
    logic              armed;
    logic              tmo_hit;

    // Clearing the lowest set bit leaves something only if two or more
    // buttons are down.
    assign s_any   = |sync_s;
    assign s_multi = |(sync_s & (sync_s - N_CAND'(1)));

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    assign armed = (state == ARMED) ||
                   (state == DEBOUNCE) ||
                   (state == RELEASE_WAIT_ARMED);

    assign o_ready   = armed;
    assign o_timeout = tmo_q;

`ifdef BALLOT_TIMEOUT_EN
    localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES);

    logic [31:0] tmr;
    logic [31:0] tmr_inc;

    assign tmr_inc = tmr + 32'd1;
    assign tmo_hit = armed && (tmr_inc >= TMO_LIM);

    // Held at zero while locked so every ballot starts a fresh window.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            tmr <= '0;
        end else if (state == LOCKED) begin
            tmr <= '0;
        end else if (armed) begin
            tmr <= tmr_inc;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        cnt_nx    = cnt;
        vote_nx   = '0;
        reject_nx = 1'b0;
        tmo_nx    = 1'b0;
        unique case (state)
            LOCKED: begin
                if (i_unlock) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (tmo_hit) begin
                    state_nx = LOCKED;
                    tmo_nx   = 1'b1;
                end else if (s_multi) begin
                    state_nx  = RELEASE_WAIT_ARMED;
                    reject_nx = 1'b1;
                end else if (s_any) begin
                    state_nx = DEBOUNCE;
                    sel_nx   = sync_s;
                    cnt_nx   = 16'd1;
                end
            end
            DEBOUNCE: begin
                // A completing debounce takes priority over expiry.
                if (sync_s == sel && cnt_inc >= DBC_LIM) begin
                    state_nx = CAST;
                    cnt_nx   = cnt_inc;
                    vote_nx  = sel;
                end else if (tmo_hit) begin
                    state_nx = LOCKED;
                    tmo_nx   = 1'b1;
                end else if (sync_s == sel) begin
                    cnt_nx = cnt_inc;
                end else begin
                    state_nx = ARMED;
                end
            end
            CAST: begin
                state_nx = RELEASE;
            end
            RELEASE: begin
                if (!s_any) begin
                    state_nx = LOCKED;
                end
            end
            RELEASE_WAIT_ARMED: begin
                if (tmo_hit) begin
                    state_nx = LOCKED;
                    tmo_nx   = 1'b1;
                end else if (!s_any) begin
                    state_nx = ARMED;
                end
            end
            default: begin
                state_nx = LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync1      <= '0;
            sync_s     <= '0;
            state      <= LOCKED;
            sel        <= '0;
            cnt        <= '0;
            o_vote     <= '0;
            o_reject   <= 1'b0;
            tmo_q      <= 1'b0;
            o_enable_n <= 1'b1;
        end else begin
            sync1      <= i_buttons;
            sync_s     <= sync1;
            state      <= state_nx;
            sel        <= sel_nx;
            cnt        <= cnt_nx;
            o_vote     <= vote_nx;
            o_reject   <= reject_nx;
            tmo_q      <= tmo_nx;
            o_enable_n <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ballot_unit.sv
// tb_ballot_unit: scoreboard bench for ballot_unit.
// Expected pulses are queued at stimulus time and matched by a monitor.

module tb_ballot_unit;

    localparam int N   = 4;
    localparam int DBC = 16;
`ifdef BALLOT_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 1024;
`endif
    localparam int LAT = DBC + 2;

    logic         clk = 1'b0;
    logic         clear = 1'b1;
    logic         unlock = 1'b0;
    logic [N-1:0] buttons = '0;
    logic [N-1:0] vote;
    logic         enable_n;
    logic         rdy;
    logic         rej;
    logic         tmo;

    ballot_unit #(
        .N_CAND(N),
        .DEBOUNCE_CYCLES(DBC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .clear(clear),
        .i_unlock(unlock),
        .i_buttons(buttons),
        .o_vote(vote),
        .o_enable_n(enable_n),
        .o_ready(rdy),
        .o_reject(rej),
        .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [N-1:0] v;
    } vote_t;

    vote_t vote_q[$];
    int    rej_q[$];
    int    tmo_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_unlock(output int at);
        @(negedge clk);
        unlock = 1'b1;
        at = cyc;
        @(negedge clk);
        unlock = 1'b0;
    endtask

    task automatic press(input logic [N-1:0] b, output int at);
        @(negedge clk);
        buttons = b;
        at = cyc;
    endtask

    task automatic expect_vote(input int at, input logic [N-1:0] b);
        vote_t e;
        e.cyc = at + LAT;
        e.v   = b;
        vote_q.push_back(e);
    endtask

    // Monitor: samples registered outputs 1 time unit after each edge.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        chk("excl", 32'((|vote) & rej), 32'(0));
        if (vote != '0) begin
            if (vote_q.size() > 0) begin
                chk("vote_cyc", 32'(cyc), 32'(vote_q[0].cyc));
                chk("vote_val", 32'(vote), 32'(vote_q[0].v));
                chk("rdy_cast", 32'(rdy), 32'(0));
                void'(vote_q.pop_front());
            end else begin
                chk("vote_unexp", 32'(vote), 32'(0));
            end
        end
        while (vote_q.size() > 0 && vote_q[0].cyc < cyc) begin
            chk("vote_miss", 32'(cyc), 32'(vote_q[0].cyc));
            void'(vote_q.pop_front());
        end
        if (rej) begin
            if (rej_q.size() > 0) begin
                chk("rej_cyc", 32'(cyc), 32'(rej_q[0]));
                void'(rej_q.pop_front());
            end else begin
                chk("rej_unexp", 32'(rej), 32'(0));
            end
        end
        while (rej_q.size() > 0 && rej_q[0] < cyc) begin
            chk("rej_miss", 32'(cyc), 32'(rej_q[0]));
            void'(rej_q.pop_front());
        end
        if (tmo) begin
            if (tmo_q.size() > 0) begin
                chk("tmo_cyc", 32'(cyc), 32'(tmo_q[0]));
                chk("tmo_rdy", 32'(rdy), 32'(0));
                void'(tmo_q.pop_front());
            end else begin
                chk("tmo_unexp", 32'(tmo), 32'(0));
            end
        end
        while (tmo_q.size() > 0 && tmo_q[0] < cyc) begin
            chk("tmo_miss", 32'(cyc), 32'(tmo_q[0]));
            void'(tmo_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got cycle %0d expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int u;

        // Reset values while clear is held.
        step(2);
        chk("rst_vote", 32'(vote), 32'(0));
        chk("rst_en_n", 32'(enable_n), 32'(1));
        chk("rst_rdy", 32'(rdy), 32'(0));
        chk("rst_rej", 32'(rej), 32'(0));
        chk("rst_tmo", 32'(tmo), 32'(0));
        clear = 1'b0;
        @(posedge clk);
        #1;
        chk("en_n_rel", 32'(enable_n), 32'(0));
        chk("rdy_lock0", 32'(rdy), 32'(0));

        // Clean vote.
        do_unlock(u);
        chk("rdy_arm", 32'(rdy), 32'(1));
        step(2);
        press(4'b0100, t);
        expect_vote(t, 4'b0100);
        step(40);
        chk("rdy_rel", 32'(rdy), 32'(0));
        buttons = '0;
        step(5);
        chk("rdy_lock1", 32'(rdy), 32'(0));

        // Bouncing button, then steady.
        do_unlock(u);
        step(2);
        for (int i = 0; i < 10; i++) begin
            buttons = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            step(5);
        end
        chk("rdy_bounce", 32'(rdy), 32'(1));
        press(4'b0010, t);
        expect_vote(t, 4'b0010);
        step(30);
        buttons = '0;
        step(5);

        // Multi-button press rejected, ballot stays armed.
        do_unlock(u);
        step(2);
        press(4'b0011, t);
        rej_q.push_back(t + 3);
        step(6);
        chk("rdy_rej", 32'(rdy), 32'(1));
        buttons = '0;
        step(5);
        chk("rdy_rwa", 32'(rdy), 32'(1));
        press(4'b1000, t);
        expect_vote(t, 4'b1000);
        step(25);
        buttons = '0;
        step(5);

        // Press while locked: nothing.
        press(4'b0001, t);
        step(30);
        buttons = '0;
        step(3);
        chk("rdy_lockpr", 32'(rdy), 32'(0));

        // Vote, then unlock while still held: no second pulse.
        do_unlock(u);
        step(2);
        press(4'b0001, t);
        expect_vote(t, 4'b0001);
        step(25);
        do_unlock(u);
        step(30);
        chk("rdy_held", 32'(rdy), 32'(0));
        buttons = '0;
        step(5);
        chk("rdy_2nd", 32'(rdy), 32'(0));
        press(4'b0001, t);
        step(30);
        buttons = '0;
        step(5);

        // Clear mid-debounce aborts the ballot.
        do_unlock(u);
        step(2);
        press(4'b0100, t);
        step(10);
        chk("rdy_deb", 32'(rdy), 32'(1));
        clear = 1'b1;
        #1;
        chk("clr_rdy", 32'(rdy), 32'(0));
        chk("clr_en_n", 32'(enable_n), 32'(1));
        chk("clr_vote", 32'(vote), 32'(0));
        chk("clr_rej", 32'(rej), 32'(0));
        chk("clr_tmo", 32'(tmo), 32'(0));
        step(2);
        clear = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_en_n0", 32'(enable_n), 32'(0));
        chk("clr_lock", 32'(rdy), 32'(0));
        step(30);
        buttons = '0;
        step(5);

`ifdef BALLOT_TIMEOUT_EN
        // Idle ballot expires.
        do_unlock(u);
        tmo_q.push_back(u + 1 + TMO);
        step(TMO + 10);
        chk("rdy_tmo", 32'(rdy), 32'(0));

        // Debounce completes on the expiry edge: vote wins.
        do_unlock(u);
        while (cyc < u + TMO - LAT) @(negedge clk);
        press(4'b0010, t);
        expect_vote(t, 4'b0010);
        step(30);
        buttons = '0;
        step(5);
`else
        // No timer: a long idle ballot stays armed.
        do_unlock(u);
        step(300);
        chk("rdy_wait", 32'(rdy), 32'(1));
        press(4'b1000, t);
        expect_vote(t, 4'b1000);
        step(25);
        buttons = '0;
        step(5);
`endif

        step(5);
        chk("vq_empty", 32'(vote_q.size()), 32'(0));
        chk("rq_empty", 32'(rej_q.size()), 32'(0));
        chk("tq_empty", 32'(tmo_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ballot_unit.md
# ballot_unit

Voter-facing front end of the polling booth: arms one ballot per officer unlock, synchronises and debounces the candidate buttons, and emits exactly one single-cycle vote pulse to the matching per-candidate counter. It drives the counters' active-low enable and pulse inputs, so it is the producing end of the counter vote interface. One ballot is accepted per unlock; extra presses, multi-button presses and held buttons never produce additional pulses.

## Interface
- N_CAND, 4: number of candidates; 2..16.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a press; 1..65535.
- TIMEOUT_CYCLES, 1024: armed-state timeout; only used with BALLOT_TIMEOUT_EN.

- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- i_unlock  in  1  officer unlock; synchronous single-cycle pulse.
- i_buttons  in  N_CAND  raw asynchronous candidate buttons, active-high.
- o_vote  out  N_CAND  one-hot, one-cycle vote pulse; bit k drives counter k's i_in.
- o_enable_n  out  1  active-low counter enable; 0 means counters enabled.
- o_ready  out  1  ballot armed, waiting for a choice.
- o_reject  out  1  one-cycle pulse when a multi-button press is detected while armed.
- o_timeout  out  1  one-cycle pulse when an armed ballot expires.

## Operation
- Reset values: o_vote=0, o_enable_n=1, o_ready=0, o_reject=0, o_timeout=0. State is LOCKED, synchronisers and debounce counter are 0.
- i_buttons pass through a 2-flop synchroniser per bit. All decisions use the synchronised vector S.
- o_enable_n is 1 only while clear is asserted. From the first clk edge after clear deasserts it is 0.
- States:
  - LOCKED: i_unlock=1 -> ARMED. Buttons are ignored.
  - ARMED: o_ready=1. If S is zero, stay. If S is one-hot, capture S in SEL, load the debounce count with 1, go to DEBOUNCE. If S has more than one bit set, pulse o_reject and go to RELEASE_WAIT_ARMED.
  - DEBOUNCE: o_ready=1. If S==SEL, increment the count; when it reaches DEBOUNCE_CYCLES, go to CAST. If S!=SEL, return to ARMED with no pulse.
  - CAST: lasts exactly one cycle with o_vote=SEL, then go to RELEASE.
  - RELEASE: wait until S==0 for one cycle, then go to LOCKED.
  - RELEASE_WAIT_ARMED: wait until S==0, then return to ARMED. The ballot stays armed.
- i_unlock is ignored in every state except LOCKED. It does not extend or restart a ballot.
- The debounce counter is 16 bits and saturates; it never wraps.
- An asserted clear in any state, including mid-DEBOUNCE or during CAST, aborts the ballot immediately. No pulse is emitted and the ballot is not resumed after reset.

## Timing
- Button to synchronised S: 2 cycles.
- A clean one-hot press held from cycle t produces o_vote at cycle t+2+DEBOUNCE_CYCLES. It is high for exactly 1 cycle.
- i_unlock sampled at edge t gives o_ready=1 from cycle t+1.
- o_ready drops in the CAST cycle.
- o_vote and o_reject are registered outputs. They are never both high in the same cycle.
- At most one o_vote pulse occurs per i_unlock.

## Configuration
- BALLOT_TIMEOUT_EN defined: a 32-bit timer runs in ARMED, DEBOUNCE and RELEASE_WAIT_ARMED. The timer clears on entry from LOCKED.
  - When it reaches TIMEOUT_CYCLES: pulse o_timeout for 1 cycle and go to LOCKED. No vote is cast.
  - If the timeout and the DEBOUNCE completion fall in the same cycle, the vote wins and the timeout is suppressed.
- BALLOT_TIMEOUT_EN undefined: there is no timer, o_timeout is tied 0, and an armed ballot waits indefinitely.

## Test plan
- Reset: assert clear mid-sim -> all outputs at reset values within the same cycle. After release, o_enable_n=0 at the next edge and state is LOCKED.
- Clean vote (N_CAND=4, DEBOUNCE_CYCLES=16): unlock, then hold i_buttons=4'b0100 for 40 cycles -> single o_vote=4'b0100 pulse 18 cycles after press, o_ready low after it, then return to LOCKED on release.
- Bounce: toggle bit 1 every 5 cycles for 50 cycles, then hold steady -> no pulse during bounce, exactly one o_vote=4'b0010 after 18 stable cycles.
- Multi-press: unlock, press 4'b0011 -> o_reject pulse, o_ready stays 1. Release, then press 4'b1000 -> o_vote=4'b1000.
- Locked and held: press buttons without unlock -> no pulse. Second unlock while still holding after a cast -> no second pulse until buttons are released and pressed again.
- Timeout (BALLOT_TIMEOUT_EN, TIMEOUT_CYCLES=100): unlock with no press -> o_timeout pulse at cycle 100, o_ready=0, no o_vote. Repeat with a press completing debounce exactly at cycle 100 -> o_vote pulses and o_timeout stays 0.
